// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment patterns are active-low {a,b,c,d,e,f,g,dp}.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    localparam logic [7:0] SS_0     = 8'b0000_0011;
    localparam logic [7:0] SS_1     = 8'b1001_1111;
    localparam logic [7:0] SS_2     = 8'b0010_0101;
    localparam logic [7:0] SS_3     = 8'b0000_1101;
    localparam logic [7:0] SS_4     = 8'b1001_1001;
    localparam logic [7:0] SS_5     = 8'b0100_1001;
    localparam logic [7:0] SS_6     = 8'b0100_0001;
    localparam logic [7:0] SS_7     = 8'b0001_1111;
    localparam logic [7:0] SS_8     = 8'b0000_0001;
    localparam logic [7:0] SS_9     = 8'b0000_1001;
    localparam logic [7:0] SS_BLANK = 8'hFF;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_PEND = 1'b1
    } hs_state_e;

endpackage

// File: rtl/ssd_bcd_dec.sv
// BCD nibble to active-low segment pattern. Non-BCD codes (A..F) show as 0.
module ssd_bcd_dec
    import ssd_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd_i,
    output logic [7:0]         segs_o
);

    always_comb begin
        segs_o = SS_0;
        case (bcd_i)
            4'd0:    segs_o = SS_0;
            4'd1:    segs_o = SS_1;
            4'd2:    segs_o = SS_2;
            4'd3:    segs_o = SS_3;
            4'd4:    segs_o = SS_4;
            4'd5:    segs_o = SS_5;
            4'd6:    segs_o = SS_6;
            4'd7:    segs_o = SS_7;
            4'd8:    segs_o = SS_8;
            4'd9:    segs_o = SS_9;
            default: segs_o = SS_0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// 4-digit common-anode display scanner with frame-aligned value updates.
// Define SSD_LZB_EN to blank leading zeros (digit 0 is never blanked).
//
//  state   | meaning
//  HS_IDLE | no value waiting, ready=1, load is accepted
//  HS_PEND | value held in pend_val, applied at the next frame boundary
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = $clog2(SCAN_DIV)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] value_in,
    input  logic                          load,
    output logic                          ready,
    output logic                          frame_done,
    output logic [NUM_DIGITS-1:0]         ssd_ctl,
    output logic [7:0]                    segs
);

    logic [DIV_W-1:0]              div_q, div_d;
    logic [1:0]                    idx_q, idx_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] shown_q, shown_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] pend_q, pend_d;
    hs_state_e                     hs_q, hs_d;
    logic                          frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]         ssd_ctl_q, ssd_ctl_d;
    logic [7:0]                    segs_q, segs_d;

    logic                          tick;
    logic                          boundary;
    logic [DIGIT_W-1:0]            nib;
    logic [7:0]                    dec_segs;
    logic                          blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= 2'd0;
            shown_q      <= '0;
            pend_q       <= '0;
            hs_q         <= HS_IDLE;
            frame_done_q <= 1'b0;
            ssd_ctl_q    <= 4'b1110;
            segs_q       <= SS_0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pend_q       <= pend_d;
            hs_q         <= hs_d;
            frame_done_q <= frame_done_d;
            ssd_ctl_q    <= ssd_ctl_d;
            segs_q       <= segs_d;
        end
    end

    always_comb begin
        tick         = (div_q == DIV_W'(SCAN_DIV - 1));
        boundary     = tick && (idx_q == 2'd3);
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        shown_d      = shown_q;
        pend_d       = pend_q;
        hs_d         = hs_q;
        frame_done_d = boundary;

        // A load on a boundary cycle lands in pend_val and waits one more frame.
        case (hs_q)
            HS_IDLE: begin
                if (load) begin
                    pend_d = value_in;
                    hs_d   = HS_PEND;
                end
            end
            HS_PEND: begin
                if (boundary) begin
                    shown_d = pend_q;
                    hs_d    = HS_IDLE;
                end
            end
            default: hs_d = HS_IDLE;
        endcase
    end

    // Outputs are computed from next-state so they switch on the same edge as idx.
    assign nib = shown_d[{idx_d, 2'b00} +: DIGIT_W];

    ssd_bcd_dec u_dec (
        .bcd_i  (nib),
        .segs_o (dec_segs)
    );

    always_comb begin
`ifdef SSD_LZB_EN
        blank = (idx_d != 2'd0) && ((shown_d >> {idx_d, 2'b00}) == '0);
`else
        blank = 1'b0;
`endif
        segs_d    = blank ? SS_BLANK : dec_segs;
        ssd_ctl_d = ~(NUM_DIGITS'(1) << idx_d);
    end

    assign ready      = (hs_q == HS_IDLE);
    assign frame_done = frame_done_q;
    assign ssd_ctl    = ssd_ctl_q;
    assign segs       = segs_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with SCAN_DIV=4: directed scenarios plus random loads,
// checked every cycle against a slot/frame arithmetic model.
module tb_ssd_scan_ctrl;

    localparam int SD = 4;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        ready;
    logic        frame_done;
    logic [3:0]  ssd_ctl;
    logic [7:0]  segs;

    int errors = 0;
    int checks = 0;

    // model state
    int          m_n     = 0;
    logic [15:0] m_shown = '0;
    logic [15:0] m_pend  = '0;
    bit          m_pending = 0;
    bit          m_fd    = 0;
    bit          m_valid = 0;

    ssd_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .ready      (ready),
        .frame_done (frame_done),
        .ssd_ctl    (ssd_ctl),
        .segs       (segs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_segs(input logic [15:0] sh, input int slot);
        logic [15:0] upper;
        logic [7:0]  p;
        upper = sh >> (4 * slot);
        case (upper[3:0])
            4'd1:    p = 8'b10011111;
            4'd2:    p = 8'b00100101;
            4'd3:    p = 8'b00001101;
            4'd4:    p = 8'b10011001;
            4'd5:    p = 8'b01001001;
            4'd6:    p = 8'b01000001;
            4'd7:    p = 8'b00011111;
            4'd8:    p = 8'b00000001;
            4'd9:    p = 8'b00001001;
            default: p = 8'b00000011;
        endcase
`ifdef SSD_LZB_EN
        if (slot > 0 && upper == 16'h0) p = 8'hFF;
`endif
        return p;
    endfunction

    // Model: after n edges since reset, slot = (n/SD)%4 and a frame ends every 4*SD edges.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_n       = 0;
                m_shown   = '0;
                m_pend    = '0;
                m_pending = 0;
                m_fd      = 0;
            end else begin
                m_n++;
                m_fd = (m_n % (4 * SD) == 0);
                if (m_fd && m_pending) begin
                    m_shown   = m_pend;
                    m_pending = 0;
                end else if (load && !m_pending) begin
                    m_pend    = value_in;
                    m_pending = 1;
                end
            end
            m_valid = 1;
        end
    end

    initial begin
        int slot;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                slot = (m_n / SD) % 4;
                chk("ssd_ctl", {12'h0, ssd_ctl}, {12'h0, ~(4'b0001 << slot)});
                chk("segs", {8'h0, segs}, {8'h0, exp_segs(m_shown, slot)});
                chk("ready", {15'h0, ready}, {15'h0, !m_pending});
                chk("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value_in = '0;
        step(3);
        chk("rst_ctl", {12'h0, ssd_ctl}, 16'h000E);
        chk("rst_segs", {8'h0, segs}, 16'h0003);
        chk("rst_ready", {15'h0, ready}, 16'h1);
        chk("rst_fd", {15'h0, frame_done}, 16'h0);
        rst = 1'b0;

        // scan rotation, n counts edges since reset release
        step(4);  chk("rot_n4", {12'h0, ssd_ctl}, 16'h000D);
        step(4);  chk("rot_n8", {12'h0, ssd_ctl}, 16'h000B);
        step(4);  chk("rot_n12", {12'h0, ssd_ctl}, 16'h0007);
        step(4);  chk("rot_n16", {12'h0, ssd_ctl}, 16'h000E);
        chk("fd_n16", {15'h0, frame_done}, 16'h1);
        step(1);  chk("fd_n17", {15'h0, frame_done}, 16'h0);

        // load 1234 mid-frame
        load = 1'b1; value_in = 16'h1234;
        step(1); load = 1'b0;
        chk("ld1234_ready", {15'h0, ready}, 16'h0);
        step(14);
        chk("ld1234_s0", {8'h0, segs}, 16'h0099);
        chk("ld1234_ready2", {15'h0, ready}, 16'h1);
        step(4);  chk("ld1234_s1", {8'h0, segs}, 16'h000D);
        step(4);  chk("ld1234_s2", {8'h0, segs}, 16'h0025);
        step(4);  chk("ld1234_s3", {8'h0, segs}, 16'h009F);

        // n=44: 5678 accepted, 9999 dropped
        load = 1'b1; value_in = 16'h5678;
        step(1); value_in = 16'h9999;
        step(2); load = 1'b0;
        step(1);  chk("ld5678_s0", {8'h0, segs}, 16'h0001);
        step(4);  chk("ld5678_s1", {8'h0, segs}, 16'h001F);
        step(4);  chk("ld5678_s2", {8'h0, segs}, 16'h0041);
        step(4);  chk("ld5678_s3", {8'h0, segs}, 16'h0049);

        // n=60: load on the boundary edge (n=64)
        step(3);
        load = 1'b1; value_in = 16'h8642;
        step(1); load = 1'b0;
        chk("bnd_s0_old", {8'h0, segs}, 16'h0001);
        chk("bnd_ready", {15'h0, ready}, 16'h0);
        step(4);  chk("bnd_s1_old", {8'h0, segs}, 16'h001F);
        step(12); chk("bnd_s0_new", {8'h0, segs}, 16'h0025);

        // n=80: non-BCD digits decode as 0
        load = 1'b1; value_in = 16'h00AF;
        step(1); load = 1'b0;
        step(15); chk("hex_s0", {8'h0, segs}, 16'h0003);
        step(4);  chk("hex_s1", {8'h0, segs}, 16'h0003);

        // n=100: leading-zero handling
        load = 1'b1; value_in = 16'h0007;
        step(1); load = 1'b0;
        step(11); chk("lz_s0", {8'h0, segs}, 16'h001F);
        step(4);
`ifdef SSD_LZB_EN
        chk("lz_s1", {8'h0, segs}, 16'h00FF);
`else
        chk("lz_s1", {8'h0, segs}, 16'h0003);
`endif

        // n=116: reset in slot 2 with a load pending
        load = 1'b1; value_in = 16'h9876;
        step(1); load = 1'b0;
        step(3);
        chk("pre_rst_ready", {15'h0, ready}, 16'h0);
        chk("pre_rst_ctl", {12'h0, ssd_ctl}, 16'h000B);
        rst = 1'b1;
        step(1);
        chk("mid_rst_ctl", {12'h0, ssd_ctl}, 16'h000E);
        chk("mid_rst_segs", {8'h0, segs}, 16'h0003);
        chk("mid_rst_ready", {15'h0, ready}, 16'h1);
        chk("mid_rst_fd", {15'h0, frame_done}, 16'h0);
        rst = 1'b0;
        step(16);
        chk("post_rst_s0", {8'h0, segs}, 16'h0003);
        chk("post_rst_fd", {15'h0, frame_done}, 16'h1);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            load     = ($urandom_range(0, 5) == 0);
            value_in = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                     : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 7) == 0) value_in[15:8] = 8'h00;
            step(1);
        end
        rst = 1'b0; load = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
